// File: rtl/sha_result_filter.sv
// Filters double-SHA256 results from the core: rebuilds each result's nonce, tests the
// h word against the block's mask, and queues winning {block_id, nonce} pairs for the host.
module sha_result_filter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            output_valid,
  input  logic            newblock_o,
  input  logic [255:0]    doublehash,
  input  logic [31:0]     nonce_base,
  input  logic [31:0]     hit_mask,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [31:0]     result_nonce,
  output logic [ID_W-1:0] result_id,
  output logic [31:0]     hash_count,
  output logic            overflow,
  output logic            nonce_wrap
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Stage 0: per-block nonce tracking
  logic [31:0]     nonce_q, nonce_d;        // nonce the next non-newblock result will use
  logic            wrap_pend_q, wrap_pend_d;
  logic [ID_W-1:0] block_id_q, block_id_d;
  logic [31:0]     mask_q, mask_d;
  logic [31:0]     hash_count_q, hash_count_d;
  logic            nonce_wrap_q, nonce_wrap_d;
  logic [31:0]     cur_nonce;

  logic            s0_valid_q;
  logic [31:0]     s0_masked_q;
  logic [31:0]     s0_nonce_q;
  logic [ID_W-1:0] s0_id_q;

  logic            hit_q;
  logic [31:0]     s1_nonce_q;
  logic [ID_W-1:0] s1_id_q;

  // Only the h word (least significant 32 bits of {a..h}) takes part in the hit test.
  logic unused_hash_bits;
  assign unused_hash_bits = ^doublehash[255:32];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nonce_d      = nonce_q;
    wrap_pend_d  = wrap_pend_q;
    block_id_d   = block_id_q;
    mask_d       = mask_q;
    hash_count_d = hash_count_q;
    nonce_wrap_d = nonce_wrap_q;
    cur_nonce    = nonce_q;
    if (output_valid) begin
      if (newblock_o) begin
        cur_nonce    = nonce_base;
        block_id_d   = block_id_q + ID_W'(1);
        mask_d       = hit_mask;
        hash_count_d = 32'd1;
        nonce_wrap_d = 1'b0;
      end else begin
        if (hash_count_q != 32'hFFFF_FFFF) hash_count_d = hash_count_q + 32'd1;
        if (wrap_pend_q) nonce_wrap_d = 1'b1;
      end
      nonce_d     = cur_nonce + 32'd1;
      wrap_pend_d = (cur_nonce == 32'hFFFF_FFFF);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nonce_q      <= '0;
      wrap_pend_q  <= 1'b0;
      block_id_q   <= '0;
      mask_q       <= 32'hFFFF_FFFF;
      hash_count_q <= '0;
      nonce_wrap_q <= 1'b0;
      s0_valid_q   <= 1'b0;
      s0_masked_q  <= '0;
      s0_nonce_q   <= '0;
      s0_id_q      <= '0;
      hit_q        <= 1'b0;
      s1_nonce_q   <= '0;
      s1_id_q      <= '0;
    end else begin
      nonce_q      <= nonce_d;
      wrap_pend_q  <= wrap_pend_d;
      block_id_q   <= block_id_d;
      mask_q       <= mask_d;
      hash_count_q <= hash_count_d;
      nonce_wrap_q <= nonce_wrap_d;
      // The mask in effect is the freshly sampled one on a newblock cycle.
      s0_valid_q   <= output_valid;
      s0_masked_q  <= doublehash[31:0] & mask_d;
      s0_nonce_q   <= cur_nonce;
      s0_id_q      <= block_id_d;
      hit_q        <= s0_valid_q && (s0_masked_q == '0);
      s1_nonce_q   <= s0_nonce_q;
      s1_id_q      <= s0_id_q;
    end
  end

  // Stage 2: result FIFO with a registered head so the outputs hold once drained
  logic [31:0]     mem_nonce [FIFO_DEPTH];
  logic [ID_W-1:0] mem_id    [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     head_nonce_q, head_nonce_d;
  logic [ID_W-1:0] head_id_q, head_id_d;
  logic            overflow_q;
  logic            full, pop, push;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && result_ready;
  assign push    = hit_q && (!full || pop);
  assign rd_next = rd_ptr_q + AW'(1);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    head_nonce_d = head_nonce_q;
    head_id_d    = head_id_q;
    if (count_d != '0) begin
      if (pop && count_q != CW'(1)) begin
        head_nonce_d = mem_nonce[rd_next];
        head_id_d    = mem_id[rd_next];
      end else if (pop || count_q == '0) begin
        head_nonce_d = s1_nonce_q;
        head_id_d    = s1_id_q;
      end
    end
  end

  // NOTE: storage is left unreset; occupancy and the head register define what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_nonce[wr_ptr_q] <= s1_nonce_q;
      mem_id[wr_ptr_q]    <= s1_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_nonce_q <= '0;
      head_id_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_next;
      count_q      <= count_d;
      head_nonce_q <= head_nonce_d;
      head_id_q    <= head_id_d;
      if (hit_q && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign result_valid = (count_q != '0);
  assign result_nonce = head_nonce_q;
  assign result_id    = head_id_q;
  assign hash_count   = hash_count_q;
  assign overflow     = overflow_q;
  assign nonce_wrap   = nonce_wrap_q;

endmodule
